// File: rtl/assoc_pkg.sv
// Shared defaults and types for the fully-associative key/value store.
package assoc_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 64;
  localparam int DW_DEF    = 64;

  // Data returned by a read that finds no matching key.
  localparam logic [DW_DEF-1:0] MISS_DATA = '0;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] key;
    logic [DW_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/assoc_match.sv
// Parallel key compare against all valid entries, encoded to a hit flag and entry index.
module assoc_match #(
  parameter int DEPTH = 8,
  parameter int AW    = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] keys_i,
  input  logic [DEPTH-1:0]         valids_i,
  input  logic [AW-1:0]            addr_i,
  output logic                     hit_o,
  output logic [IW-1:0]            idx_o
);

  logic [DEPTH-1:0] onehot;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign onehot[gi] = valids_i[gi] && (keys_i[gi] == addr_i);
  end

  assign hit_o = |onehot;

  // Keys are unique, so at most one bit is set and OR-ing indices is a valid encode.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (onehot[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule

// File: rtl/assoc_mem.sv
// Fully-associative key/value store with lowest-free allocation and FIFO replacement when full.
module assoc_mem
  import assoc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wen,
  input  logic                   ren,
  input  logic [AW-1:0]          addr,
  input  logic [DW-1:0]          wdin,
  output logic [DW-1:0]          rdout,
  output logic                   rvalid,
  output logic                   rhit,
  output logic                   evict,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] key_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [IW-1:0]            rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DW-1:0]            rdout_q, rdout_d;
  logic                     rvalid_q, rhit_q, rhit_d, evict_q, evict_d;

  logic          w_hit, r_hit, full, wr_en;
  logic [IW-1:0] w_idx, r_idx, free_idx, wr_idx;

  assoc_match #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_wr_match (
    .keys_i   (key_q),
    .valids_i (valid_q),
    .addr_i   (addr),
    .hit_o    (w_hit),
    .idx_o    (w_idx)
  );

  assoc_match #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_rd_match (
    .keys_i   (key_q),
    .valids_i (valid_q),
    .addr_i   (addr),
    .hit_o    (r_hit),
    .idx_o    (r_idx)
  );

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = w_idx;
    valid_d = valid_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    evict_d = 1'b0;
    if (wen) begin
      wr_en = 1'b1;
      if (!w_hit && !full) begin
        wr_idx           = free_idx;
        valid_d[free_idx] = 1'b1;
        count_d          = count_q + CW'(1);
      end else if (!w_hit) begin
        // Entry at rptr is the oldest because allocation fills 0..DEPTH-1 in order.
        wr_idx  = rptr_q;
        rptr_d  = rptr_q + IW'(1);
        evict_d = 1'b1;
      end
    end
  end

  // Read observes pre-write state, so a same-cycle allocating write reads as a miss.
  always_comb begin
    rhit_d  = rhit_q;
    rdout_d = rdout_q;
    if (ren) begin
      rhit_d  = r_hit;
      rdout_d = r_hit ? data_q[r_idx] : DW'(MISS_DATA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdout_q  <= '0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
      evict_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdout_q  <= rdout_d;
      rvalid_q <= ren;
      rhit_q   <= rhit_d;
      evict_q  <= evict_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_q[wr_idx]  <= addr;
      data_q[wr_idx] <= wdin;
    end
  end

  assign rdout  = rdout_q;
  assign rvalid = rvalid_q;
  assign rhit   = rhit_q;
  assign evict  = evict_q;
  assign count  = count_q;

endmodule
